// File: rtl/vga_fb_arbiter.sv
// Frame-buffer arbiter: display fetch is time-sliced off the VGA counters and
// serialised to pixels; all other memory cycles are handed to one CPU port.
module vga_fb_arbiter #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 400,
  parameter int unsigned ADDR_W   = 15,
  parameter int unsigned DATA_W   = 64
) (
  input  logic              clk25,
  input  logic              reset,
  input  logic [9:0]        horizontal,
  input  logic [8:0]        vertical,
  input  logic              disp_en,
  output logic              disp_running,
  output logic [7:0]        pix_out,
  output logic              pix_valid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned WORDS_PER_LINE = H_ACTIVE / 8;
  localparam int unsigned PIX_W          = 8;
  localparam logic [9:0]  H_ACT          = 10'(H_ACTIVE);
  localparam logic [8:0]  V_ACT          = 9'(V_ACTIVE);
  localparam logic [9:0]  H_LAST         = 10'd799;
  localparam logic [8:0]  V_LAST         = 9'd448;

  logic              in_window;
  logic              slot;
  logic [ADDR_W-1:0] disp_addr;
  logic              win_d1;
  logic [DATA_W-1:0] shift_reg;
  logic [DATA_W-1:0] rdata_q;

  // Fetch window and the one-in-eight slot inside it
  assign in_window = disp_running && (vertical < V_ACT) && (horizontal < H_ACT);
  assign slot      = in_window && (horizontal[2:0] == 3'd0);
  assign disp_addr = ADDR_W'(vertical) * ADDR_W'(WORDS_PER_LINE) + ADDR_W'(horizontal[9:3]);

  // Display slot always wins; CPU gets every other cycle it asks for
  assign cpu_ack   = reset && cpu_req && !slot;
  assign mem_en    = reset && (slot || cpu_req);
  assign mem_we    = cpu_ack && cpu_we;
  assign mem_addr  = slot ? disp_addr : cpu_addr;
  assign mem_wdata = cpu_wdata;

  // Read data is forwarded in its valid cycle and held afterwards
  assign cpu_rdata = cpu_rvalid ? mem_rdata : rdata_q;
  assign pix_out   = pix_valid ? shift_reg[PIX_W-1:0] : '0;

  always_ff @(posedge clk25 or negedge reset) begin
    if (!reset) begin
      disp_running <= 1'b0;
      win_d1       <= 1'b0;
      pix_valid    <= 1'b0;
      shift_reg    <= '0;
      cpu_rvalid   <= 1'b0;
      rdata_q      <= '0;
    end else begin
      if (horizontal == H_LAST && vertical == V_LAST)
        disp_running <= disp_en;
      win_d1    <= in_window;
      pix_valid <= win_d1;
      // Word arrives the cycle after its slot; byte 0 is the leftmost pixel
      if (horizontal[2:0] == 3'd1)
        shift_reg <= mem_rdata;
      else
        shift_reg <= shift_reg >> PIX_W;
      cpu_rvalid <= cpu_ack && !cpu_we;
      if (cpu_rvalid)
        rdata_q <= mem_rdata;
    end
  end

endmodule
